// File: rtl/fetch_sequencer.sv
// fetch_sequencer: boot-loads the instruction memory, then sequences the PC through it.
module fetch_sequencer #(
    parameter int A  = 6,
    parameter int W  = 8,
    parameter int CW = 16
) (
    input  logic          CLK,
    input  logic          Reset,
    input  logic          Load_start,
    input  logic          Load_valid,
    input  logic          Load_last,
    input  logic [W-1:0]  Load_data,
    input  logic          Start,
    input  logic [A-1:0]  Start_addr,
    input  logic          Stall,
    input  logic          Branch_en,
    input  logic          Branch_rel,
    input  logic [A-1:0]  Target,
    input  logic          Halt,
    output logic          write_enable,
    output logic [A-1:0]  InstAddress,
    output logic [W-1:0]  InputData,
    output logic          Instr_valid,
    output logic          Load_done,
    output logic          Done,
    output logic [CW-1:0] Instr_count
);
    typedef enum logic [1:0] {IDLE, LOAD, RUN, HALTED} state_t;
    state_t       state;
    logic [A-1:0] pc, ptr;
    logic [CW-1:0] cnt_inc;
    assign cnt_inc = Instr_count + CW'(Instr_count != '1);
    // The write strobe is gated by Reset so an aborted load never writes.
    assign write_enable = (state == LOAD) && Load_valid && !Reset;
    assign InstAddress  = (state == LOAD) ? ptr : pc;
    assign InputData    = (state == LOAD) ? Load_data : '0;
    assign Instr_valid  = (state == RUN) && !Stall;
    assign Done         = (state == HALTED);
    always_ff @(posedge CLK) begin
        if (Reset) begin
            state       <= IDLE;
            pc          <= '0;
            ptr         <= '0;
            Instr_count <= '0;
            Load_done   <= 1'b0;
        end else begin
            Load_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (Load_start) begin
                        state <= LOAD;
                        ptr   <= '0;
                    end else if (Start) begin
                        state       <= RUN;
                        pc          <= Start_addr;
                        Instr_count <= '0;
                    end
                end
                LOAD: begin
                    if (Load_valid) begin
                        ptr <= ptr + 1'b1;
                        // A write at the top address ends the load; the pointer is never reused after wrapping.
                        if (Load_last || ptr == '1) begin
                            state     <= IDLE;
                            Load_done <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (!Stall) begin
                        Instr_count <= cnt_inc;
                        if (Halt) state <= HALTED;
                        else pc <= Branch_en ? (Branch_rel ? pc + Target : Target) : pc + 1'b1;
                    end
                end
                HALTED: begin
                    if (Start) begin
                        state       <= RUN;
                        pc          <= Start_addr;
                        Instr_count <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Controller that drives the address and write side of the 64×8 instruction memory.
- Handles two jobs:
  - Boot loading: streams program bytes into memory through its write port.
  - Fetch sequencing: runs the program counter that addresses memory during execution, including jumps, stalls and halt.
- Memory read is combinational, so the instruction word for the current address is valid in the same cycle. Instr_valid qualifies it.

Parameters:
A, 6, address width; memory depth is 2^A.
W, 8, data word width.
CW, 16, retired-instruction counter width.

Ports:
CLK  input  1  clock, all state changes on rising edge
Reset  input  1  synchronous, active-high reset
Load_start  input  1  request to enter LOAD (sampled in IDLE only)
Load_valid  input  1  Load_data valid this cycle (LOAD only)
Load_last  input  1  marks final load byte; qualified by Load_valid
Load_data  input  W  byte to write
Start  input  1  begin execution (sampled in IDLE or HALTED)
Start_addr  input  A  initial PC on Start
Stall  input  1  freeze PC this cycle
Branch_en  input  1  take jump this cycle
Branch_rel  input  1  1: PC-relative jump, 0: absolute jump
Target  input  A  absolute target, or signed two's-complement offset
Halt  input  1  stop execution after current instruction
write_enable  output  1  memory write strobe
InstAddress  output  A  memory address
InputData  output  W  memory write data
Instr_valid  output  1  memory output is a live instruction this cycle
Load_done  output  1  one-cycle pulse when load completes
Done  output  1  level, high while HALTED
Instr_count  output  CW  instructions retired since last Start

Behaviour:
- States: IDLE, LOAD, RUN, HALTED. Encoding is free.
- Reset (sync, highest priority, any state):
  - State goes to IDLE; PC and load pointer go to 0; Instr_count goes to 0.
  - All outputs are 0 in the cycle after Reset is sampled.
  - Reset asserted mid-load or mid-run aborts immediately. No write occurs in a cycle where Reset is high.
- IDLE:
  - Load_start → LOAD with load pointer = 0.
  - Else Start → RUN with PC = Start_addr and Instr_count = 0.
  - Load_start wins if both are asserted.
  - Outputs: write_enable = 0, Instr_valid = 0, InstAddress = PC.
- LOAD:
  - InstAddress = load pointer; InputData = Load_data; write_enable = Load_valid. All combinational, same cycle.
  - Each Load_valid cycle: pointer increments.
  - Load ends if (Load_valid & Load_last), or if a Load_valid write lands at address 2^A−1. The top address forces termination and the pointer never wraps.
  - On end: next state IDLE; Load_done = 1 for exactly the following cycle.
  - Load_valid = 0 cycles: no write, pointer holds.
  - Start is ignored in LOAD.
- RUN:
  - InstAddress = PC; Instr_valid = ~Stall; write_enable = 0.
  - Priority per cycle: Stall > Halt > Branch_en > sequential.
    - Stall: PC, state and count all hold; Halt and Branch are ignored.
    - Halt: instruction at PC retires (count+1); state → HALTED; PC holds.
    - Branch_en: count+1; PC = Branch_rel ? (PC + Target) mod 2^A : Target.
    - Otherwise: count+1; PC = (PC+1) mod 2^A, so 2^A−1 wraps to 0.
  - Instr_count saturates at 2^CW−1.
  - Start and Load_start are ignored in RUN.
- HALTED:
  - Done = 1; Instr_valid = 0; PC and count hold.
  - Start → RUN with PC = Start_addr and count = 0. Done drops in the next cycle.
  - Load_start is ignored; return to IDLE only via Reset.
- Latency:
  - Address to instruction: 0 cycles (combinational memory).
  - PC update: 1 cycle.

Test Plan:
- Reset, then Load_start, then 5 Load_valid bytes 0x11..0x15 with Load_last on the 5th → write_enable high on 5 cycles at addresses 0..4; Load_done pulses once; state IDLE.
- Load 70 consecutive valid bytes without Load_last → writes at addresses 0..63 only; Load_done after the write at 63; no write to address 0 a second time.
- Start with Start_addr=62, no branches, 4 cycles → InstAddress 62, 63, 0, 1; Instr_count=4.
- In RUN at PC=10: Branch_rel=1, Target=0x3E (−2) → next PC 8. Then Branch_rel=0, Target=40 → PC 40. Stall held 3 cycles → PC stays 40, count unchanged, Instr_valid=0.
- Halt and Branch_en asserted together at PC=5 → HALTED, PC 5, Done=1, count incremented once. Then Start with Start_addr=20 → RUN at PC 20, count 0, Done=0.
- Reset asserted in the middle of LOAD with Load_valid high → no write that cycle; next cycle IDLE with all outputs 0.
